module_codificador_hamming: RTL and testbench

//  Transmit-side SECDED encoder: extended Hamming(8,4) (Hamming(7,4) plus even global parity).

---
 rtl/module_codificador_hamming.sv | 100 ++++++++++
 tb/tb_module_codificador_hamming.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_codificador_hamming.sv
// SECDED transmit encoder: extended Hamming(8,4) with optional per-word error injection,
// two registered stages with valid/ready on both sides, one word per cycle.
module module_codificador_hamming #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [7:0]       in_mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic             out_injected,
    output logic [CNT_W-1:0] words_sent
);

    logic             s1_v_reg;
    logic [3:0]       s1_data_reg;
    logic [7:0]       s1_mask_reg;
    logic             s2_v_reg;
    logic [7:0]       code_reg;
    logic             injected_reg;
    logic [CNT_W-1:0] words_sent_reg;

    logic             s1_load;
    logic             s2_load;
    logic             out_fire;
    logic [7:0]       clean_code;
    logic [7:0]       code_next;

    assign out_fire = s2_v_reg && out_ready;
    assign s2_load  = s1_v_reg && (!s2_v_reg || out_ready);
    assign in_ready = !s1_v_reg || !s2_v_reg || out_ready;
    assign s1_load  = in_valid && in_ready;

    // Bit order must match module_detector_error: Hamming positions 1..7 on cw[0..6], pg on cw[7].
    always_comb begin
        clean_code    = 8'h00;
        clean_code[0] = s1_data_reg[0] ^ s1_data_reg[1] ^ s1_data_reg[3];
        clean_code[1] = s1_data_reg[0] ^ s1_data_reg[2] ^ s1_data_reg[3];
        clean_code[2] = s1_data_reg[0];
        clean_code[3] = s1_data_reg[1] ^ s1_data_reg[2] ^ s1_data_reg[3];
        clean_code[4] = s1_data_reg[1];
        clean_code[5] = s1_data_reg[2];
        clean_code[6] = s1_data_reg[3];
        clean_code[7] = ^clean_code[6:0];
    end

    // Mask goes on after pg so injected errors are visible to the detector's global parity.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_inject
            assign code_next[gi] = clean_code[gi] ^ s1_mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_reg    <= 1'b0;
            s1_data_reg <= 4'h0;
            s1_mask_reg <= 8'h00;
        end else if (s1_load) begin
            s1_v_reg    <= 1'b1;
            s1_data_reg <= in_data;
            s1_mask_reg <= in_mask;
        end else if (s2_load) begin
            s1_v_reg    <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v_reg     <= 1'b0;
            code_reg     <= 8'h00;
            injected_reg <= 1'b0;
        end else if (s2_load) begin
            s2_v_reg     <= 1'b1;
            code_reg     <= code_next;
            injected_reg <= |s1_mask_reg;
        end else if (out_fire) begin
            s2_v_reg     <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            words_sent_reg <= '0;
        end else if (out_fire) begin
            words_sent_reg <= words_sent_reg + CNT_W'(1);
        end
    end

    assign out_valid    = s2_v_reg;
    assign out_code     = code_reg;
    assign out_injected = injected_reg;
    assign words_sent   = words_sent_reg;

endmodule

// File: tb/tb_module_codificador_hamming.sv
// Bench for the Hamming(8,4) encoder: queue-based reference model checked every cycle,
// plus directed encode/injection, backpressure, counter-wrap and reset-mid-stall scenarios.
module tb_module_codificador_hamming;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic [7:0]       in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_code;
    logic             out_injected;
    logic [CNT_W-1:0] words_sent;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] code;
        logic       inj;
        int         acc;
    } item_t;

    item_t            exp_q[$];
    logic [CNT_W-1:0] sent_model = '0;

    module_codificador_hamming #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_mask      (in_mask),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_code     (out_code),
        .out_injected (out_injected),
        .words_sent   (words_sent)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference encoder from the Hamming construction: data fills non-power-of-two
    // positions, parity at 2^b covers every position with bit b set, then overall even parity.
    function automatic logic [7:0] ref_code(input logic [3:0] d);
        logic [7:0] cw;
        int         k;
        logic       x;
        cw = 8'h00;
        k  = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 3; b++) begin
            x = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (((pos >> b) & 1) == 1 && pos != (1 << b)) x = x ^ cw[pos-1];
            cw[(1 << b) - 1] = x;
        end
        cw[7] = ^cw[6:0];
        return cw;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the queue model; sampled at negedge, inputs are stable then.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            sent_model = '0;
        end else begin
            chk("in_ready", 16'(in_ready), 16'((exp_q.size() < 2) || out_ready));
            chk("out_valid", 16'(out_valid),
                16'((exp_q.size() > 0) && (cyc >= exp_q[0].acc + 1)));
            if (out_valid && exp_q.size() > 0) begin
                chk("out_code", 16'(out_code), 16'(exp_q[0].code));
                chk("out_injected", 16'(out_injected), 16'(exp_q[0].inj));
            end
            chk("words_sent", 16'(words_sent), 16'(sent_model));
            if (out_valid && out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                sent_model = sent_model + 1'b1;
            end
            if (in_valid && in_ready) begin
                item_t it;
                it.code = ref_code(in_data) ^ in_mask;
                it.inj  = (in_mask != 8'h00);
                it.acc  = cyc + 1;
                exp_q.push_back(it);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    // Sends one word into an idle pipeline and checks it against a hand-computed codeword.
    task automatic directed(input string name, input logic [3:0] d, input logic [7:0] m,
                            input logic [7:0] exp_code, input logic exp_inj);
        bit seen;
        chk({"model_", name}, 16'(ref_code(d) ^ m), 16'(exp_code));
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = d;
        in_mask   = m;
        step();
        in_valid  = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                chk({name, "_code"}, 16'(out_code), 16'(exp_code));
                chk({name, "_inj"}, 16'(out_injected), 16'(exp_inj));
            end
        end
        if (!seen) chk({name, "_timeout"}, 16'(0), 16'(1));
        step();
    endtask

    initial begin
        logic [3:0] bp [3];
        logic [7:0] held_code;
        logic [CNT_W-1:0] ws_before;
        int idx;
        bit acc_now;

        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; in_mask = 8'h00; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 16'(out_valid), 16'(0));
        chk("rst_out_code", 16'(out_code), 16'(0));
        chk("rst_words_sent", 16'(words_sent), 16'(0));
        step(); step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 16'(in_ready), 16'(1));

        directed("enc0000", 4'b0000, 8'h00, 8'h00, 1'b0);
        directed("enc0001", 4'b0001, 8'h00, 8'h87, 1'b0);
        directed("enc1011", 4'b1011, 8'h00, 8'h55, 1'b0);
        directed("enc1111", 4'b1111, 8'h00, 8'hFF, 1'b0);
        directed("inj_single", 4'b1011, 8'h04, 8'h51, 1'b1);
        directed("inj_double", 4'b1011, 8'h03, 8'h56, 1'b1);

        // All 16 nibbles back-to-back; the monitor flags any bubble or ordering error.
        out_ready = 1'b1;
        for (int d = 0; d < 16; d++) begin
            in_valid = 1'b1; in_data = 4'(d); in_mask = 8'h00;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();

        // Backpressure: three words offered with the output stalled.
        bp[0] = 4'h3; bp[1] = 4'hA; bp[2] = 4'h6;
        ws_before = words_sent;
        out_ready = 1'b0;
        idx = 0;
        held_code = 8'h00;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 3);
            in_data  = bp[idx < 3 ? idx : 2];
            in_mask  = 8'h00;
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (c == 2) held_code = out_code;
            step();
            if (acc_now) idx++;
        end
        chk("bp_accepts", 16'(idx), 16'(2));
        chk("bp_in_ready", 16'(in_ready), 16'(0));
        chk("bp_held_code", 16'(out_code), 16'(held_code));
        chk("bp_held_code_val", 16'(out_code), 16'(ref_code(bp[0])));
        out_ready = 1'b1;
        for (int c = 0; c < 10 && idx < 3; c++) begin
            in_valid = 1'b1; in_data = bp[idx]; in_mask = 8'h00;
            @(negedge clk);
            acc_now = in_valid && in_ready;
            step();
            if (acc_now) idx++;
        end
        in_valid = 1'b0;
        repeat (5) step();
        chk("bp_drained", 16'(words_sent), 16'(ws_before + 4'd3));

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom_range(0, 15));
            in_mask   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) step();

        // Counter wrap with a 4-bit counter.
        do_reset();
        chk("cnt_after_rst", 16'(words_sent), 16'(0));
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; in_data = 4'(i); in_mask = 8'h00;
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("cnt_15", 16'(words_sent), 16'(15));
        in_valid = 1'b1; in_data = 4'h9;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("cnt_wrap", 16'(words_sent), 16'(0));

        // Reset in the middle of a stall with two words held.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'h5; in_mask = 8'h10;
        step();
        in_data = 4'hC; in_mask = 8'h00;
        step();
        in_valid = 1'b0;
        step();
        chk("stall_full", 16'(in_ready), 16'(0));
        chk("stall_valid", 16'(out_valid), 16'(1));
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(out_valid), 16'(0));
        chk("midrst_words_sent", 16'(words_sent), 16'(0));
        chk("midrst_out_code", 16'(out_code), 16'(0));
        step();
        rst = 1'b0;
        step();
        chk("midrst_in_ready", 16'(in_ready), 16'(1));
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no_stale_word", 16'(out_valid), 16'(0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
